// File: rtl/mem_bus_arbiter_ts_pkg.sv
// Shared constants, state encoding and helpers
// for the two-port memory bus arbiter.
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 64;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic logic [1:0] port_onehot(
    input logic p
  );
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_ts_if.sv
// Requester/arbiter bundle: per-port request side
// plus the registered memory strobes and status.
interface mem_bus_arbiter_ts_if
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [1:0]             req;
  logic [1:0]             we;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0][DATA_W-1:0] rdata;
  logic [1:0]             ack;
  logic [1:0]             grant;
  logic                   busy;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_oe;
  logic                   mem_we;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, grant, busy,
    input  mem_addr, mem_oe, mem_we
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, grant, busy,
    output mem_addr, mem_oe, mem_we
  );

endinterface

// File: rtl/mem_bus_arbiter_ts_rr_arbiter_2.sv
// Two-way round-robin pick: on a tie the port
// not served last wins.
module rr_arbiter_2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_idx
);

  assign o_valid = |i_req;

  always_comb begin
    o_idx = 1'b0;
    unique case (1'b1)
      (i_req == 2'b11): o_idx = ~i_last;
      (i_req == 2'b10): o_idx = 1'b1;
      default:          o_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter_ts.sv
// Two-port arbiter and setup/access/done sequencer
// for the shared tristate memory data bus.
module mem_bus_arbiter_ts
  import mem_bus_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  mem_bus_arbiter_ts_if.slave bus,
  inout  wire  [DATA_W-1:0]   io_mem_data
);

  localparam int CW =
    (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  state_e                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_port;
  logic                   r_we;
  logic                   r_last;
  logic                   r_drv;
  logic                   r_oe;
  logic                   r_mwe;
  logic                   r_busy;
  logic [1:0]             r_grant;
  logic [1:0]             r_ack;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [1:0][DATA_W-1:0] r_rdata;

  logic w_valid;
  logic w_idx;

  rr_arbiter_2 u_rr (
    .i_req   (bus.req),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_port  <= PORT_CPU;
      r_we    <= 1'b0;
      r_last  <= PORT_DMA;
      r_drv   <= 1'b0;
      r_oe    <= 1'b0;
      r_mwe   <= 1'b0;
      r_busy  <= 1'b0;
      r_grant <= '0;
      r_ack   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_ack <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_port  <= w_idx;
            r_we    <= bus.we[w_idx];
            r_addr  <= bus.addr[w_idx];
            r_wdata <= bus.wdata[w_idx];
            r_grant <= port_onehot(w_idx);
            r_drv   <= bus.we[w_idx];
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_cnt   <= CW'(WAIT_STATES);
          r_oe    <= ~r_we;
          r_mwe   <= r_we;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_oe    <= 1'b0;
            r_mwe   <= 1'b0;
            r_drv   <= 1'b0;
            r_ack   <= port_onehot(r_port);
            r_state <= DONE;
            if (!r_we) r_rdata[r_port] <= io_mem_data;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_last  <= r_port;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // DONE leaves the bus released as a turnaround cycle
  assign io_mem_data  = r_drv ? r_wdata : 'z;
  assign bus.mem_addr = r_addr;
  assign bus.mem_oe   = r_oe;
  assign bus.mem_we   = r_mwe;
  assign bus.grant    = r_grant;
  assign bus.busy     = r_busy;
  assign bus.ack      = r_ack;
  assign bus.rdata    = r_rdata;

endmodule

// File: doc/mem_bus_arbiter_ts.md
# mem_bus_arbiter_ts

Two-port arbiter and bus sequencer that shares the single 64-bit tristate memory data bus and 32-bit address bus between the LEGv8 CPU (port 0) and a second master such as a DMA/loader (port 1). It grants one requester at a time with round-robin fairness and runs a fixed setup/access/done bus cycle with a configurable number of wait states. It drives the strobes and the tristate bus, captures read data and returns a one-cycle acknowledge. It sits between the CPU top level and the memory/peripheral bus.

## Interface
- WAIT_STATES, 2, extra strobe cycles beyond the minimum one-cycle access (0..15)
- ADDR_W, 32, address width
- DATA_W, 64, data width
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0 / req1  in  1  transaction request, level-sensitive; held until ack
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  transaction address
- wdata0 / wdata1  in  DATA_W  write data
- rdata0 / rdata1  out  DATA_W  registered read data, valid when ack pulses for a read
- ack0 / ack1  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  memory address bus
- mem_data  inout  DATA_W  shared tristate data bus
- mem_oe  out  1  read strobe
- mem_we  out  1  write strobe
- grant  out  2  one-hot owner of the current transaction, 0 when idle
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: if any req is high, arbitrate, latch the winner's we/addr/wdata and the grant, then go to SETUP. With no request, stay in IDLE.
- Arbitration: a single requester wins. When both request, the port not served last wins. last_served resets to 1, so port 0 wins the first tie.
- SETUP (1 cycle):
  - mem_addr valid, strobes low.
  - mem_data driven with the latched wdata if the transaction is a write, otherwise hi-Z.
- ACCESS (WAIT_STATES+1 cycles): mem_oe (read) or mem_we (write) is high. On the last ACCESS edge, a read captures mem_data into the granted port's rdata register. Then go to DONE.
- DONE (1 cycle):
  - strobes low; mem_data hi-Z (turnaround cycle).
  - ack of the granted port high; update last_served.
  - then go to IDLE.
- A requester keeping req high after ack is served again (back-to-back). It still loses any tie to the other port.
- req dropping mid-transaction is ignored: the transaction completes and ack still pulses.
- Changes to we/addr/wdata after the SETUP latch have no effect.
- rdata holds its value until the next read completes on that port. Writes never change rdata.
- mem_data is driven only in SETUP/ACCESS of a write. It is never driven during reset, IDLE or DONE.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE, grant 0, busy 0, ack0/1 0, mem_oe/mem_we 0, mem_addr 0, mem_data hi-Z.
  - rdata0/1 0, last_served 1, wait counter 0.
- Reset asserted mid-transaction aborts immediately with no ack. Strobes and bus drive drop asynchronously.
- Latency: req sampled at edge E → SETUP after E → ACCESS after E+1 → DONE after E+2+WAIT_STATES.
- ack is high for the cycle following edge E+2+WAIT_STATES. For WAIT_STATES=2 that is edge E+4.
- Minimum IDLE dwell is 1 cycle between transactions. Back-to-back throughput is one transaction per WAIT_STATES+4 cycles.
- All outputs are registered. There is no combinational path from req to grant, strobes or ack.
- The wait counter is $clog2(WAIT_STATES+1) bits (minimum 1). It loads on SETUP exit and decrements in ACCESS; ACCESS exits at 0.

## Structure
- Shared package mem_bus_pkg: state encoding localparams (IDLE, SETUP, ACCESS, DONE), default DATA_W/ADDR_W, and port index constants PORT_CPU=0 and PORT_DMA=1.
- Sub-module rr_arbiter_2: combinational two-way round-robin pick from req[1:0] and last_served. It is instantiated once and used only in IDLE.
- The top module holds the FSM, the latches, the wait counter and the tristate assign.

## Test plan
- Read on port 0, WAIT_STATES=2: req0, addr0=0x100, memory model returns 0xDEADBEEF00000001.
  - mem_oe high exactly 3 cycles; grant=01.
  - ack0 one-cycle pulse after edge E+4; rdata0=0xDEADBEEF00000001; mem_data hi-Z throughout.
- Write on port 1: we1=1, addr1=0x2000, wdata1=0x0123456789ABCDEF.
  - mem_data carries that value during SETUP+ACCESS (4 cycles); mem_we high 3 cycles.
  - bus hi-Z in DONE; ack1 pulses; rdata1 unchanged.
- Simultaneous req0 and req1 held high for 4 transactions: grant order 01, 10, 01, 10; every ack matches its grant; busy low exactly 1 cycle between each.
- Reset asserted in the second ACCESS cycle of a write: strobes 0, mem_data hi-Z and grant 0 immediately; no ack. After release, a pending req0 is served from IDLE normally.
- WAIT_STATES=0 instance, single read: strobe high 1 cycle; ack after edge E+2.
- req0 dropped one cycle after SETUP entry: transaction still completes, ack0 pulses once, FSM returns to IDLE and stays there.
